// File: rtl/z_core_alu_arb.sv
// Shared-ALU controller: round-robin arbitration of two requesters onto one
// z_core_alu, with registered operands, per-op hold time and a registered result.
module z_core_alu_arb #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned OP_W    = 5
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_in1,
  input  logic [31:0]     req0_in2,
  input  logic [OP_W-1:0] req0_op,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_in1,
  input  logic [31:0]     req1_in2,
  input  logic [OP_W-1:0] req1_op,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,

  output logic [31:0]     rsp_result,
  output logic            rsp_branch,

  output logic [31:0]     alu_in1,
  output logic [31:0]     alu_in2,
  output logic [OP_W-1:0] alu_op,
  input  logic [31:0]     alu_out,
  input  logic            alu_branch
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Extra hold cycles for multiplies; the count covers cycles beyond the first.
  localparam logic [3:0] CNT_MUL = 4'(MUL_LAT - 1);

  localparam logic [OP_W-1:0] OP_MUL_FIRST = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MUL_LAST  = OP_W'(19);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [31:0]     alu_in1_q, alu_in1_d;
  logic [31:0]     alu_in2_q, alu_in2_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_branch_q, rsp_branch_d;

  logic            in_idle;
  logic            any_req;
  logic            grant;
  logic [31:0]     sel_in1;
  logic [31:0]     sel_in2;
  logic [OP_W-1:0] sel_op;
  logic            sel_is_mul;
  logic            cur_illegal;
  logic            owner_rsp_ready;

  // Arbitration: a lone requester wins; under contention the port that did not
  // win last time gets the grant.
  always_comb begin
    in_idle = (state_q == IDLE);
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
  end

  always_comb begin
    sel_in1 = grant ? req1_in1 : req0_in1;
    sel_in2 = grant ? req1_in2 : req0_in2;
    sel_op  = grant ? req1_op  : req0_op;
  end

  always_comb begin
    sel_is_mul      = (sel_op >= OP_MUL_FIRST) && (sel_op <= OP_MUL_LAST);
    cur_illegal     = (alu_op_q > OP_MUL_LAST);
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
  end

  // rstn gating keeps ready low while reset is held with requests pending.
  always_comb begin
    req0_ready = rstn & in_idle & any_req & ~grant;
    req1_ready = rstn & in_idle & any_req & grant;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_branch_d = rsp_branch_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          alu_in1_d    = sel_in1;
          alu_in2_d    = sel_in2;
          alu_op_d     = sel_op;
          last_grant_d = grant;
          owner_d      = grant;
          cnt_d        = sel_is_mul ? CNT_MUL : 4'd0;
          state_d      = EXEC;
        end
      end

      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (cur_illegal) begin
            rsp_result_d = 32'd0;
            rsp_branch_d = 1'b0;
          end else begin
            rsp_result_d = alu_out;
            rsp_branch_d = alu_branch;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        if (owner_rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_in1_q    <= 32'd0;
      alu_in2_q    <= 32'd0;
      alu_op_q     <= '0;
      rsp_result_q <= 32'd0;
      rsp_branch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_branch_q <= rsp_branch_d;
    end
  end

  always_comb begin
    rsp0_valid = (state_q == RESP) & ~owner_q;
    rsp1_valid = (state_q == RESP) & owner_q;
    rsp_result = rsp_result_q;
    rsp_branch = rsp_branch_q;
    alu_in1    = alu_in1_q;
    alu_in2    = alu_in2_q;
    alu_op     = alu_op_q;
  end

endmodule
